music_decoder: RTL and testbench

//  Receive-side counterpart of the tone generator: samples a square-wave/PWM tone line, measures the

---
 rtl/music_pkg.sv | 73 +++++++
 rtl/music_decoder_if.sv | 19 +
 rtl/note_classifier.sv | 71 +++++++
 rtl/music_decoder.sv | 174 +++++++++++++++++
 tb/tb_music_decoder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the tone-line decoder: note frequency table,
// special note codes, FSM state encoding and the nominal-period helper.
package music_pkg;

    localparam int NUM_NOTES = 21;

    localparam logic [4:0] NOTE_SILENCE = 5'd0;
    localparam logic [4:0] NOTE_UNKNOWN = 5'd31;

    // Note frequencies in Hz: low, middle and high octave.
    localparam int unsigned l_1 = 131;
    localparam int unsigned l_2 = 147;
    localparam int unsigned l_3 = 165;
    localparam int unsigned l_4 = 175;
    localparam int unsigned l_5 = 196;
    localparam int unsigned l_6 = 220;
    localparam int unsigned l_7 = 247;
    localparam int unsigned m_1 = 262;
    localparam int unsigned m_2 = 294;
    localparam int unsigned m_3 = 330;
    localparam int unsigned m_4 = 349;
    localparam int unsigned m_5 = 392;
    localparam int unsigned m_6 = 440;
    localparam int unsigned m_7 = 494;
    localparam int unsigned h_1 = 523;
    localparam int unsigned h_2 = 587;
    localparam int unsigned h_3 = 659;
    localparam int unsigned h_4 = 698;
    localparam int unsigned h_5 = 784;
    localparam int unsigned h_6 = 880;
    localparam int unsigned h_7 = 988;

    typedef enum logic [2:0] {
        S_WAIT,
        S_MEASURE,
        S_CLASSIFY,
        S_UPDATE,
        S_SILENCE
    } state_t;

    // Frequency of table entry idx (code idx+1).
    function automatic int unsigned note_freq(input int idx);
        case (idx)
            0:       return l_1;
            1:       return l_2;
            2:       return l_3;
            3:       return l_4;
            4:       return l_5;
            5:       return l_6;
            6:       return l_7;
            7:       return m_1;
            8:       return m_2;
            9:       return m_3;
            10:      return m_4;
            11:      return m_5;
            12:      return m_6;
            13:      return m_7;
            14:      return h_1;
            15:      return h_2;
            16:      return h_3;
            17:      return h_4;
            18:      return h_5;
            19:      return h_6;
            default: return h_7;
        endcase
    endfunction

    // Nominal period in clock cycles of table entry idx.
    function automatic logic [31:0] note_period(input int idx, input int unsigned clk_freq);
        return clk_freq / note_freq(idx);
    endfunction

endpackage

// File: rtl/music_decoder_if.sv
// Tone line in, decoded note stream out. The decoder takes the slave side.
interface music_decoder_if;
    logic        music_in;
    logic [4:0]  cur_note;
    logic        locked;
    logic        note_valid;
    logic [4:0]  note_code;
    logic [31:0] note_len;

    modport master (
        output music_in,
        input  cur_note, locked, note_valid, note_code, note_len
    );

    modport slave (
        input  music_in,
        output cur_note, locked, note_valid, note_code, note_len
    );
endinterface

// File: rtl/note_classifier.sv
// Sequential note-table scan: one entry per cycle, first window hit wins,
// NOTE_UNKNOWN when no entry matches. done pulses once the code is final.
module note_classifier
    import music_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned TOL_SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] meas,
    output logic        done,
    output logic [4:0]  code
);

    localparam int IDX_W = $clog2(NUM_NOTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

    // NOTE: the table is constant wiring folded at elaboration, not storage, so it has no reset.
    logic [31:0] nom_tab [NUM_NOTES];
    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_tab
        assign nom_tab[i] = note_period(i, CLK_FREQ);
    end

    logic             busy;
    logic [IDX_W-1:0] idx;
    logic [31:0]      meas_r;
    logic [31:0]      nom;
    logic [31:0]      tol;
    logic             hit;

    // Window test of the latched period against the entry under the scan pointer.
    always_comb begin
        // NOTE: every output gets a value before any condition so no latch is inferred.
        nom = nom_tab[idx];
        tol = nom >> TOL_SHIFT;
        hit = (meas_r >= nom - tol) && (meas_r <= nom + tol);
    end

    // Scan pointer, first-match capture and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
        if (!rst) begin
            busy   <= 1'b0;
            idx    <= '0;
            meas_r <= '0;
            done   <= 1'b0;
            code   <= NOTE_SILENCE;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                idx    <= '0;
                meas_r <= meas;
                code   <= NOTE_UNKNOWN;
            end else if (busy) begin
                if (hit && code == NOTE_UNKNOWN) begin
                    code <= 5'(idx) + 5'd1;
                end
                if (idx == LAST_IDX) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/music_decoder.sv
// Tone-line decoder: synchronises the pin, measures rising-edge periods,
// classifies them against the note table, debounces note changes and
// reports each finished note with its length in clock cycles.
module music_decoder
    import music_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned TOL_SHIFT      = 6,
    parameter int unsigned STABLE_CNT     = 4,
    parameter int unsigned SILENCE_CYCLES = CLK_FREQ / 100
) (
    input  logic            clk,
    input  logic            rst,
    music_decoder_if.slave  bus
);

    localparam int STAB_W = $clog2(STABLE_CNT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);

    logic              sync1, sync2, sync3, edge_r;
    logic [31:0]       period_cnt;
    state_t            state, state_nxt;
    logic              cls_start, cls_done;
    logic [4:0]        cls_code;
    logic [31:0]       meas;

    logic [4:0]        cand, cand_nxt;
    logic [STAB_W-1:0] stab_cnt, stab_nxt;
    logic [4:0]        cur_note, cur_nxt;
    logic              end_note;
    logic [31:0]       len_cnt, len_inc;
    logic              note_valid;
    logic [4:0]        note_code;
    logic [31:0]       note_len;

    // Two-flop synchroniser plus a delay flop; edge_r is a registered rising-edge strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            sync1  <= bus.music_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_r <= sync2 & ~sync3;
        end
    end

    // Cycles since the last edge, saturating at the silence threshold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (edge_r) begin
            period_cnt <= '0;
        end else if (period_cnt != SILENCE_CYCLES) begin
            period_cnt <= period_cnt + 32'd1;
        end
    end

    // The count at the closing edge is one short of the full edge-to-edge period.
    assign meas = period_cnt + 32'd1;

    note_classifier #(
        .CLK_FREQ  (CLK_FREQ),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_classifier (
        .clk   (clk),
        .rst   (rst),
        .start (cls_start),
        .meas  (meas),
        .done  (cls_done),
        .code  (cls_code)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and classifier launch.
    always_comb begin
        state_nxt = state;
        cls_start = 1'b0;
        case (state)
            S_WAIT: begin
                if (edge_r) state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                if (edge_r) begin
                    cls_start = 1'b1;
                    state_nxt = S_CLASSIFY;
                end else if (period_cnt == SILENCE_CYCLES) begin
                    state_nxt = S_SILENCE;
                end
            end
            S_CLASSIFY: begin
                if (cls_done) state_nxt = S_UPDATE;
            end
            S_UPDATE:  state_nxt = S_MEASURE;
            S_SILENCE: state_nxt = S_WAIT;
            default:   state_nxt = S_WAIT;
        endcase
    end

    // Candidate tracking, stability count and note change / end decisions.
    always_comb begin
        cand_nxt = cand;
        stab_nxt = stab_cnt;
        cur_nxt  = cur_note;
        end_note = 1'b0;
        if (state == S_UPDATE) begin
            if (cls_code == NOTE_UNKNOWN) begin
                stab_nxt = '0;
            end else if (cls_code == cand) begin
                if (stab_cnt != STAB_MAX) stab_nxt = stab_cnt + STAB_W'(1);
            end else begin
                cand_nxt = cls_code;
                stab_nxt = STAB_W'(1);
            end
            if (stab_nxt == STAB_MAX && cand_nxt != cur_note) begin
                end_note = (cur_note != NOTE_SILENCE);
                cur_nxt  = cand_nxt;
            end
        end else if (state == S_SILENCE) begin
            end_note = (cur_note != NOTE_SILENCE);
            cur_nxt  = NOTE_SILENCE;
            cand_nxt = NOTE_SILENCE;
            stab_nxt = '0;
        end
    end

    // Reported length includes the final cycle the note was current.
    assign len_inc = (len_cnt == '1) ? len_cnt : len_cnt + 32'd1;

    // Note state, duration counter and end-of-note report registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand       <= NOTE_SILENCE;
            stab_cnt   <= '0;
            cur_note   <= NOTE_SILENCE;
            len_cnt    <= '0;
            note_valid <= 1'b0;
            note_code  <= NOTE_SILENCE;
            note_len   <= '0;
        end else begin
            cand       <= cand_nxt;
            stab_cnt   <= stab_nxt;
            cur_note   <= cur_nxt;
            note_valid <= end_note;
            if (end_note) begin
                note_code <= cur_note;
                note_len  <= len_inc;
            end
            if (end_note || cur_note == NOTE_SILENCE) begin
                len_cnt <= '0;
            end else begin
                len_cnt <= len_inc;
            end
        end
    end

    assign bus.cur_note   = cur_note;
    assign bus.locked     = (cur_note != NOTE_SILENCE);
    assign bus.note_valid = note_valid;
    assign bus.note_code  = note_code;
    assign bus.note_len   = note_len;

endmodule

// File: tb/tb_music_decoder.sv
// Directed bench for music_decoder. Runs at a reduced clock frequency so the
// note periods stay short; the period table scales with CLK_FREQ.
module tb_music_decoder;

    localparam int unsigned CLK_FREQ = 250_000;   // silence threshold = 2500 cycles
    // Hand-computed periods: 250000/392, 250000/523, 250000/330 (integer division).
    localparam int P_M5  = 637;   // m_5, code 12, window 628..646
    localparam int P_H1  = 478;   // h_1, code 15
    localparam int P_M3  = 757;   // m_3, code 10, window 746..768
    localparam int P_ODD = 600;   // between m_6 (560..576) and m_5 (628..646)
    localparam int P_OFF = 740;   // between m_4 (705..727) and m_3 (746..768)
    localparam int P_SIL = 3000;  // idle time longer than the silence threshold

    logic clk = 1'b0;
    logic rst = 1'b0;

    music_decoder_if dut_if ();

    music_decoder #(
        .CLK_FREQ (CLK_FREQ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   pulse_cnt = 0;
    int   run_len   = 0;
    logic [4:0] last_cur = '0;
    time  pulse_t = 0;
    time  rise_t  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One square-wave period per iteration, rising edge first, 50% duty.
    task automatic drive(input int period, input int count);
        for (int k = 0; k < count; k++) begin
            dut_if.music_in = 1'b1;
            rise_t = $time;
            repeat (period / 2) @(negedge clk);
            dut_if.music_in = 1'b0;
            repeat (period - period / 2) @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cur_note"},   dut_if.cur_note,   5'd0);
        check({tag, "_locked"},     dut_if.locked,     1'b0);
        check({tag, "_note_valid"}, dut_if.note_valid, 1'b0);
        check({tag, "_note_code"},  dut_if.note_code,  5'd0);
        check({tag, "_note_len"},   dut_if.note_len,   32'd0);
    endtask

    // Scoreboard: counts the cycles each note is current and checks every report against it.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            run_len  = 0;
            last_cur = '0;
        end else begin
            if (dut_if.note_valid) begin
                check("pulse_len",  dut_if.note_len,  run_len);
                check("pulse_code", dut_if.note_code, last_cur);
                pulse_cnt++;
                pulse_t = $time;
            end
            if (dut_if.cur_note != last_cur) begin
                run_len  = (dut_if.cur_note != 5'd0) ? 1 : 0;
                last_cur = dut_if.cur_note;
            end else if (last_cur != 5'd0) begin
                run_len++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of stimulus, expected finish before 2 ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int delta;

        dut_if.music_in = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // 1: m_5 locks only after the fifth edge, without a report.
        base = pulse_cnt;
        drive(P_M5, 4);
        check("t1_not_yet", dut_if.cur_note, 5'd0);
        drive(P_M5, 1);
        check("t1_cur_note", dut_if.cur_note, 5'd12);
        check("t1_locked",   dut_if.locked,   1'b1);
        check("t1_pulses",   pulse_cnt,       base);

        // 2: change to h_1 reports the m_5 note once.
        drive(P_H1, 5);
        check("t2_pulses",    pulse_cnt,        base + 1);
        check("t2_note_code", dut_if.note_code, 5'd12);
        check("t2_cur_note",  dut_if.cur_note,  5'd15);

        // 3: silence ends h_1 at the timeout.
        repeat (P_SIL) @(negedge clk);
        delta = int'((pulse_t - rise_t) / 10);
        check("t3_pulses",    pulse_cnt,        base + 2);
        check("t3_note_code", dut_if.note_code, 5'd15);
        check("t3_delay",     (delta >= 2500 && delta <= 2510), 1'b1);
        check("t3_cur_note",  dut_if.cur_note,  5'd0);
        check("t3_locked",    dut_if.locked,    1'b0);

        // 4: a single odd period inside an m_3 stream is ignored.
        drive(P_M3, 5);
        check("t4_lock", dut_if.cur_note, 5'd10);
        drive(P_ODD, 1);
        drive(P_M3, 6);
        check("t4_cur_note", dut_if.cur_note, 5'd10);
        check("t4_pulses",   pulse_cnt,       base + 2);
        repeat (P_SIL) @(negedge clk);
        check("t4_end_pulses", pulse_cnt,        base + 3);
        check("t4_end_code",   dut_if.note_code, 5'd10);

        // 5: periods outside every window never lock.
        drive(P_OFF, 10);
        check("t5_cur_note", dut_if.cur_note, 5'd0);
        check("t5_locked",   dut_if.locked,   1'b0);
        repeat (P_SIL) @(negedge clk);
        check("t5_pulses", pulse_cnt, base + 3);

        // 6: reset during classification while locked.
        drive(P_M5, 5);
        check("t6_locked", dut_if.cur_note, 5'd12);
        dut_if.music_in = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        dut_if.music_in = 1'b0;
        @(negedge clk);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2 * P_M5) @(negedge clk);
        check("t6_no_pulse", pulse_cnt, base + 3);
        drive(P_M5, 4);
        check("t6_relock_early", dut_if.cur_note, 5'd0);
        drive(P_M5, 1);
        check("t6_relock",       dut_if.cur_note, 5'd12);
        check("t6_final_pulses", pulse_cnt,       base + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
